mixer_splitter4: RTL and testbench

MIXER_SPLITTER4 -- requirements
Module: mixer_splitter4

---
 rtl/mixer_splitter4_if.sv | 27 ++
 rtl/mixer_splitter4.sv | 122 ++++++++++++
 tb/tb_mixer_splitter4.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mixer_splitter4_if.sv
// Bus bundle for mixer_splitter4: a TDM sample stream in, four registered channel
// outputs plus frame status out. The master drives samples, the slave is the mixer.
interface mixer_splitter4_if #(
  parameter int BITSIZE = 16
);
  logic signed [BITSIZE-1:0] in;
  logic                      in_valid;
  logic                      frame_start;
  logic [7:0]                gain;
  logic signed [BITSIZE-1:0] out1;
  logic signed [BITSIZE-1:0] out2;
  logic signed [BITSIZE-1:0] out3;
  logic signed [BITSIZE-1:0] out4;
  logic                      out_valid;
  logic                      overflow;
  logic                      frame_err;

  modport master (
    output in, in_valid, frame_start, gain,
    input  out1, out2, out3, out4, out_valid, overflow, frame_err
  );

  modport slave (
    input  in, in_valid, frame_start, gain,
    output out1, out2, out3, out4, out_valid, overflow, frame_err
  );
endinterface

// File: rtl/mixer_splitter4.sv
// Four-channel TDM splitter with per-channel power-of-two gain.
// Define MIXER_SPLITTER_SATURATE_EN to clamp scaled samples and report overflow; otherwise they wrap.
module mixer_splitter4 #(
  parameter int BITSIZE = 16
) (
  input  logic              clk,
  input  logic              reset,
  mixer_splitter4_if.slave  bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 chIdx_q, chIdx_d;
  logic [2:0][BITSIZE-1:0]    stage_q, stage_d;
  logic [2:0]                 clip_q, clip_d;
  logic [3:0][BITSIZE-1:0]    out_q, out_d;
  logic                       outValid_q, outValid_d;
  logic                       overflow_q, overflow_d;
  logic                       frameErr_q, frameErr_d;

  logic [1:0]                 shift;
  logic [BITSIZE-1:0]         scaled;
  logic                       scaledClip;

  // A frame_start sample is always channel 1, so it takes the ch1 gain field even mid-frame.
  always_comb begin
    shift = bus.gain[1:0];
    if (state_q == COLLECT && !bus.frame_start) begin
      shift = bus.gain[{chIdx_q, 1'b0} +: 2];
    end
  end

`ifdef MIXER_SPLITTER_SATURATE_EN
  localparam logic signed [BITSIZE+2:0] SAT_MAX = $signed({4'b0000, {(BITSIZE-1){1'b1}}});
  localparam logic signed [BITSIZE+2:0] SAT_MIN = $signed({4'b1111, {(BITSIZE-1){1'b0}}});

  logic signed [BITSIZE+2:0] wide;

  always_comb begin
    wide       = $signed({{3{bus.in[BITSIZE-1]}}, bus.in}) <<< shift;
    scaled     = wide[BITSIZE-1:0];
    scaledClip = 1'b0;
    if (wide > SAT_MAX) begin
      scaled     = {1'b0, {(BITSIZE-1){1'b1}}};
      scaledClip = 1'b1;
    end else if (wide < SAT_MIN) begin
      scaled     = {1'b1, {(BITSIZE-1){1'b0}}};
      scaledClip = 1'b1;
    end
  end
`else
  always_comb begin
    scaled     = bus.in <<< shift;
    scaledClip = 1'b0;
  end
`endif

  // Channels 1..3 wait in the staging registers; channel 4 goes straight to the outputs with them.
  always_comb begin
    state_d    = state_q;
    chIdx_d    = chIdx_q;
    stage_d    = stage_q;
    clip_d     = clip_q;
    out_d      = out_q;
    outValid_d = 1'b0;
    overflow_d = 1'b0;
    frameErr_d = 1'b0;
    if (bus.in_valid) begin
      if (bus.frame_start) begin
        frameErr_d = (state_q == COLLECT);
        stage_d[0] = scaled;
        clip_d[0]  = scaledClip;
        chIdx_d    = 2'd1;
        state_d    = COLLECT;
      end else if (state_q == COLLECT) begin
        if (chIdx_q == 2'd3) begin
          out_d      = {scaled, stage_q[2], stage_q[1], stage_q[0]};
          outValid_d = 1'b1;
          overflow_d = (|clip_q) | scaledClip;
          chIdx_d    = 2'd0;
          state_d    = IDLE;
        end else begin
          stage_d[chIdx_q] = scaled;
          clip_d[chIdx_q]  = scaledClip;
          chIdx_d          = chIdx_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      chIdx_q    <= 2'd0;
      stage_q    <= '0;
      clip_q     <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chIdx_q    <= chIdx_d;
      stage_q    <= stage_d;
      clip_q     <= clip_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      overflow_q <= overflow_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign bus.out1      = out_q[0];
  assign bus.out2      = out_q[1];
  assign bus.out3      = out_q[2];
  assign bus.out4      = out_q[3];
  assign bus.out_valid = outValid_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frameErr_q;

endmodule

// File: tb/tb_mixer_splitter4.sv
// Self-checking bench for mixer_splitter4: directed vector table, reset sequence,
// then random traffic against a queue-based frame model (honours MIXER_SPLITTER_SATURATE_EN).
module tb_mixer_splitter4;
  localparam int BITSIZE = 16;

`ifdef MIXER_SPLITTER_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mixer_splitter4_if #(.BITSIZE(BITSIZE)) bus();

  mixer_splitter4 #(.BITSIZE(BITSIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       fs;
    int       d;
    bit [7:0] g;
    bit       ev;
    int       e1, e2, e3, e4;
    bit       eo;
    bit       ee;
  } vec_t;

  vec_t vecs[$];

  int mq[$];
  bit mclip[$];
  int mOut[4];
  bit mValid, mOvf, mErr;

  function automatic vec_t row(bit v, bit fs, int d, bit [7:0] g, bit ev,
                               int e1, int e2, int e3, int e4, bit eo, bit ee);
    vec_t r;
    r.v = v; r.fs = fs; r.d = d; r.g = g; r.ev = ev;
    r.e1 = e1; r.e2 = e2; r.e3 = e3; r.e4 = e4; r.eo = eo; r.ee = ee;
    return r;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(string tag, bit ev, int e1, int e2, int e3, int e4, bit eo, bit ee);
    checkOutput({tag, " out_valid"}, int'(bus.out_valid), int'(ev));
    checkOutput({tag, " out1"}, int'(bus.out1), e1);
    checkOutput({tag, " out2"}, int'(bus.out2), e2);
    checkOutput({tag, " out3"}, int'(bus.out3), e3);
    checkOutput({tag, " out4"}, int'(bus.out4), e4);
    checkOutput({tag, " overflow"}, int'(bus.overflow), int'(eo));
    checkOutput({tag, " frame_err"}, int'(bus.frame_err), int'(ee));
  endtask

  task automatic applyStimulus(bit v, bit fs, int d, bit [7:0] g);
    bus.in_valid    = v;
    bus.frame_start = fs;
    bus.in          = 16'(d);
    bus.gain        = g;
    @(posedge clk);
    #1;
  endtask

  // Reference scaling: multiply by 2^sh, then clamp or keep the low 16 bits.
  function automatic void scaleRef(int d, int sh, output int r, output bit c);
    longint    p;
    logic [15:0] t;
    p = longint'(d) * (longint'(1) << sh);
    c = 1'b0;
    if (SAT == 1) begin
      if (p > 32767) begin r = 32767; c = 1'b1; end
      else if (p < -32768) begin r = -32768; c = 1'b1; end
      else r = int'(p);
    end else begin
      t = p[15:0];
      r = int'($signed(t));
    end
  endfunction

  function automatic void modelReset();
    mq.delete();
    mclip.delete();
    for (int i = 0; i < 4; i++) mOut[i] = 0;
  endfunction

  function automatic void modelStep(bit v, bit fs, int d, bit [7:0] g);
    int r;
    bit c;
    int k;
    mValid = 1'b0; mOvf = 1'b0; mErr = 1'b0;
    if (v) begin
      if (fs) begin
        if (mq.size() != 0) mErr = 1'b1;
        mq.delete();
        mclip.delete();
        scaleRef(d, int'(g[1:0]), r, c);
        mq.push_back(r);
        mclip.push_back(c);
      end else if (mq.size() != 0) begin
        k = mq.size();
        scaleRef(d, int'((g >> (2 * k)) & 8'd3), r, c);
        mq.push_back(r);
        mclip.push_back(c);
        if (mq.size() == 4) begin
          for (int i = 0; i < 4; i++) begin
            mOut[i] = mq[i];
            if (mclip[i]) mOvf = 1'b1;
          end
          mValid = 1'b1;
          mq.delete();
          mclip.delete();
        end
      end
    end
  endfunction

  initial begin
    int W1;
    int pulses;
    bit v, fs;
    int d;
    bit [7:0] g;

    W1 = (SAT == 1) ? 32767 : 0;

    // Frame 100..400 unscaled
    vecs.push_back(row(1, 1, 100, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 0, 200, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 0, 300, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 0, 400, 8'h00, 1, 100, 200, 300, 400, 0, 0));
    vecs.push_back(row(0, 0, 0,   8'h00, 0, 100, 200, 300, 400, 0, 0));
    // Gains ch1..ch4 = 3,2,1,0 in the 2-bit field map is 8'h1B
    vecs.push_back(row(1, 1, 8192,  8'h1B, 0, 100, 200, 300, 400, 0, 0));
    vecs.push_back(row(1, 0, -8192, 8'h1B, 0, 100, 200, 300, 400, 0, 0));
    vecs.push_back(row(1, 0, 1,     8'h1B, 0, 100, 200, 300, 400, 0, 0));
    vecs.push_back(row(1, 0, -1,    8'h1B, 1, W1, -32768, 2, -1, bit'(SAT), 0));
    vecs.push_back(row(0, 0, 0,     8'h1B, 0, W1, -32768, 2, -1, 0, 0));
    // Resync: partial 5,6 dropped when 7 arrives with frame_start
    vecs.push_back(row(1, 1, 5,  8'h00, 0, W1, -32768, 2, -1, 0, 0));
    vecs.push_back(row(1, 0, 6,  8'h00, 0, W1, -32768, 2, -1, 0, 0));
    vecs.push_back(row(1, 1, 7,  8'h00, 0, W1, -32768, 2, -1, 0, 1));
    vecs.push_back(row(1, 0, 8,  8'h00, 0, W1, -32768, 2, -1, 0, 0));
    vecs.push_back(row(1, 0, 9,  8'h00, 0, W1, -32768, 2, -1, 0, 0));
    vecs.push_back(row(1, 0, 10, 8'h00, 1, 7, 8, 9, 10, 0, 0));
    // Back-to-back frames, second frame_start lands in the out_valid cycle
    vecs.push_back(row(1, 1, 11, 8'h00, 0, 7, 8, 9, 10, 0, 0));
    vecs.push_back(row(1, 0, 12, 8'h00, 0, 7, 8, 9, 10, 0, 0));
    vecs.push_back(row(1, 0, 13, 8'h00, 0, 7, 8, 9, 10, 0, 0));
    vecs.push_back(row(1, 0, 14, 8'h00, 1, 11, 12, 13, 14, 0, 0));
    vecs.push_back(row(1, 1, 15, 8'h00, 0, 11, 12, 13, 14, 0, 0));
    vecs.push_back(row(1, 0, 16, 8'h00, 0, 11, 12, 13, 14, 0, 0));
    vecs.push_back(row(1, 0, 17, 8'h00, 0, 11, 12, 13, 14, 0, 0));
    vecs.push_back(row(1, 0, 18, 8'h00, 1, 15, 16, 17, 18, 0, 0));
    // Stray sample while idle, then a gain-1 frame with 3-cycle gaps
    vecs.push_back(row(1, 0, 99, 8'h55, 0, 15, 16, 17, 18, 0, 0));
    for (int s = 3; s <= 6; s++) begin
      vecs.push_back(row(1, (s == 3), s, 8'h55, (s == 6),
                         (s == 6) ? 6 : 15, (s == 6) ? 8 : 16,
                         (s == 6) ? 10 : 17, (s == 6) ? 12 : 18, 0, 0));
      if (s != 6)
        for (int k = 0; k < 3; k++)
          vecs.push_back(row(0, 0, 0, 8'h55, 0, 15, 16, 17, 18, 0, 0));
    end

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.frame_start = 1'b0; bus.in = '0; bus.gain = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].fs, vecs[i].d, vecs[i].g);
      checkAll($sformatf("vec%0d", i), vecs[i].ev, vecs[i].e1, vecs[i].e2,
               vecs[i].e3, vecs[i].e4, vecs[i].eo, vecs[i].ee);
    end

    // Reset mid-frame: outputs clear asynchronously, next frame needs frame_start
    applyStimulus(1, 1, 1, 8'h00);
    applyStimulus(1, 0, 2, 8'h00);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checkAll("async rst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkAll("held rst", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 0, 3, 8'h00);
    checkAll("post rst stray", 0, 0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int s = 1; s <= 7; s++) begin
      applyStimulus(s <= 4, s == 1, s, 8'h00);
      if (bus.out_valid) pulses++;
      if (s < 4) checkAll("post rst frame", 0, 0, 0, 0, 0, 0, 0);
      else checkAll("post rst frame", s == 4, 1, 2, 3, 4, 0, 0);
    end
    checkOutput("post rst pulses", pulses, 1);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 9) < 7);
      fs = ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 2))
        0:       d = int'($urandom_range(0, 600)) - 300;
        1:       d = int'($urandom_range(0, 65535)) - 32768;
        default: d = int'($urandom_range(0, 16384)) - 8192;
      endcase
      g = 8'($urandom_range(0, 255));
      applyStimulus(v, fs, d, g);
      modelStep(v, fs, d, g);
      checkAll($sformatf("rand%0d", n), mValid, mOut[0], mOut[1], mOut[2], mOut[3], mOvf, mErr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
